machine_timer: RTL and testbench

Memory-mapped machine timer and software-interrupt source for a single RV32 hart, CLINT register layout. Drives the `xTIP` and `xSIP` interrupt-pending inputs of the hart's CSR file; `xEIP` comes from elsewhere. The timer sits on the core's data bus as a single-outstanding slave.

---
 rtl/clint_pkg.sv | 33 +++
 rtl/tick_prescaler.sv | 28 ++
 rtl/machine_timer.sv | 124 ++++++++++++
 tb/tb_machine_timer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared definitions for the CLINT-layout machine timer: register offsets,
// bus FSM states and the offset decoder.
package clint_pkg;

  localparam logic [15:0] MSIP_OFF        = 16'h0000;
  localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
  localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;
  localparam logic [15:0] MTIME_LO_OFF    = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_OFF    = 16'hBFFC;

  typedef enum logic {IDLE, RESP} clint_bus_state_t;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_MSIP,
    REG_CMP_LO,
    REG_CMP_HI,
    REG_TIME_LO,
    REG_TIME_HI
  } clint_reg_t;

  function automatic clint_reg_t clint_decode(input logic [15:0] off);
    case (off)
      MSIP_OFF:        return REG_MSIP;
      MTIMECMP_LO_OFF: return REG_CMP_LO;
      MTIMECMP_HI_OFF: return REG_CMP_HI;
      MTIME_LO_OFF:    return REG_TIME_LO;
      MTIME_HI_OFF:    return REG_TIME_HI;
      default:         return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk by TICK_DIV; tick is high on the wrap cycle of the count.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/machine_timer.sv
// CLINT-layout machine timer / software-interrupt slave for one RV32 hart,
// single-outstanding request/response bus.
module machine_timer
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1,
  parameter logic [31:0] BASE     = 32'h0200_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        xTIP,
  output logic        xSIP
);

  clint_bus_state_t state_q, state_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        xtip_q, xsip_q;

  logic        tick;
  logic        accept;
  logic        wr;
  clint_reg_t  sel;
  logic [31:0] rd_val;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    sel         = REG_NONE;
    rd_val      = '0;
    mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d  = mtimecmp_q;
    msip_d      = msip_q;
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    if (req_addr[31:16] == BASE[31:16] && req_addr[1:0] == 2'b00)
      sel = clint_decode(req_addr[15:0]);

    req_ready = (state_q == IDLE) || rsp_ready;
    accept    = req_valid && req_ready;
    wr        = accept && req_we && (sel != REG_NONE);

    case (sel)
      REG_MSIP:    rd_val = {31'd0, msip_q};
      REG_CMP_LO:  rd_val = mtimecmp_q[31:0];
      REG_CMP_HI:  rd_val = mtimecmp_q[63:32];
      REG_TIME_LO: rd_val = mtime_q[31:0];
      REG_TIME_HI: rd_val = mtime_q[63:32];
      default:     rd_val = '0;
    endcase

    // A software write to mtime overrides that cycle's increment.
    if (wr) begin
      case (sel)
        REG_MSIP:    msip_d     = req_wdata[0];
        REG_CMP_LO:  mtimecmp_d = {mtimecmp_q[63:32], req_wdata};
        REG_CMP_HI:  mtimecmp_d = {req_wdata, mtimecmp_q[31:0]};
        REG_TIME_LO: mtime_d    = {mtime_q[63:32], req_wdata};
        REG_TIME_HI: mtime_d    = {req_wdata, mtime_q[31:0]};
        default:     ;
      endcase
    end

    if (accept) begin
      rsp_rdata_d = req_we ? 32'd0 : rd_val;
      rsp_err_d   = (sel == REG_NONE);
    end

    case (state_q)
      IDLE:    if (accept) state_d = RESP;
      RESP:    if (rsp_ready && !req_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      msip_q      <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      xtip_q      <= 1'b0;
      xsip_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      xtip_q      <= (mtime_q >= mtimecmp_q);
      xsip_q      <= msip_q;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign xTIP      = xtip_q;
  assign xSIP      = xsip_q;

endmodule

// File: tb/tb_machine_timer.sv
// Self-checking bench: two timers (TICK_DIV=1 and 4) checked every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_machine_timer;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_ready;
  } bus_t;

  typedef struct {
    logic [63:0] mtime;
    logic [63:0] cmp;
    logic        msip;
    int          cnt;
    logic        rv;
    logic [31:0] rdata;
    logic        err;
    logic        tip;
    logic        sip;
  } model_t;

  localparam logic [31:0] A_MSIP   = 32'h0200_0000;
  localparam logic [31:0] A_CMP_LO = 32'h0200_4000;
  localparam logic [31:0] A_CMP_HI = 32'h0200_4004;
  localparam logic [31:0] A_TM_LO  = 32'h0200_BFF8;
  localparam logic [31:0] A_TM_HI  = 32'h0200_BFFC;

  logic        clk;
  logic        rst;
  bus_t        b [2];
  logic        rdy_w [2];
  logic        rv_w  [2];
  logic [31:0] rd_w  [2];
  logic        err_w [2];
  logic        tip_w [2];
  logic        sip_w [2];

  model_t      m [2];
  logic        armed;
  int          tests;
  int          fails;

  machine_timer #(.TICK_DIV(1)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(b[0].valid), .req_ready(rdy_w[0]), .req_we(b[0].we),
    .req_addr(b[0].addr), .req_wdata(b[0].wdata),
    .rsp_valid(rv_w[0]), .rsp_ready(b[0].rsp_ready),
    .rsp_rdata(rd_w[0]), .rsp_err(err_w[0]),
    .xTIP(tip_w[0]), .xSIP(sip_w[0])
  );

  machine_timer #(.TICK_DIV(4)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(b[1].valid), .req_ready(rdy_w[1]), .req_we(b[1].we),
    .req_addr(b[1].addr), .req_wdata(b[1].wdata),
    .rsp_valid(rv_w[1]), .rsp_ready(b[1].rsp_ready),
    .rsp_rdata(rd_w[1]), .rsp_err(err_w[1]),
    .xTIP(tip_w[1]), .xSIP(sip_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of the timer behaviour, from the register map and rules only.
  function automatic model_t step(input model_t mo, input int div, input logic r, input bus_t bb);
    model_t      n;
    logic        tk;
    logic        acc;
    logic        hit;
    logic [31:0] val;
    n = mo;
    if (r) begin
      n.mtime = '0; n.cmp = '1; n.msip = 1'b0; n.cnt = 0;
      n.rv = 1'b0; n.rdata = '0; n.err = 1'b0; n.tip = 1'b0; n.sip = 1'b0;
      return n;
    end
    tk      = (mo.cnt == div - 1);
    n.cnt   = tk ? 0 : mo.cnt + 1;
    n.mtime = tk ? mo.mtime + 64'd1 : mo.mtime;
    n.tip   = (mo.mtime >= mo.cmp);
    n.sip   = mo.msip;
    acc     = bb.valid && (!mo.rv || bb.rsp_ready);
    if (acc) begin
      hit = 1'b1;
      val = '0;
      if (bb.addr[31:16] != 16'h0200 || bb.addr[1:0] != 2'b00) hit = 1'b0;
      else begin
        case (bb.addr[15:0])
          16'h0000: begin val = {31'd0, mo.msip};  if (bb.we) n.msip = bb.wdata[0]; end
          16'h4000: begin val = mo.cmp[31:0];      if (bb.we) n.cmp[31:0] = bb.wdata; end
          16'h4004: begin val = mo.cmp[63:32];     if (bb.we) n.cmp[63:32] = bb.wdata; end
          16'hBFF8: begin val = mo.mtime[31:0];    if (bb.we) n.mtime = {mo.mtime[63:32], bb.wdata}; end
          16'hBFFC: begin val = mo.mtime[63:32];   if (bb.we) n.mtime = {bb.wdata, mo.mtime[31:0]}; end
          default:  hit = 1'b0;
        endcase
      end
      n.rv    = 1'b1;
      n.err   = !hit;
      n.rdata = (bb.we || !hit) ? 32'd0 : val;
    end else if (mo.rv && bb.rsp_ready) begin
      n.rv = 1'b0;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m[0] = step(m[0], 1, rst, b[0]);
    m[1] = step(m[1], 4, rst, b[1]);
    if (rst) armed = 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("d%0d rsp_valid", i), 64'(rv_w[i]), 64'(m[i].rv));
        check($sformatf("d%0d req_ready", i), 64'(rdy_w[i]), 64'(!m[i].rv || b[i].rsp_ready));
        check($sformatf("d%0d xTIP", i), 64'(tip_w[i]), 64'(m[i].tip));
        check($sformatf("d%0d xSIP", i), 64'(sip_w[i]), 64'(m[i].sip));
        if (m[i].rv) begin
          check($sformatf("d%0d rsp_rdata", i), 64'(rd_w[i]), 64'(m[i].rdata));
          check($sformatf("d%0d rsp_err", i), 64'(err_w[i]), 64'(m[i].err));
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wr(input int i, input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk);
    #1 b[i].valid = 1'b1; b[i].we = 1'b1; b[i].addr = addr; b[i].wdata = data;
    @(posedge clk);
    #1 b[i].valid = 1'b0; b[i].we = 1'b0;
  endtask

  task automatic rd(input int i, input logic [31:0] addr, output logic [31:0] data, output logic err);
    @(posedge clk);
    #1 b[i].valid = 1'b1; b[i].we = 1'b0; b[i].addr = addr;
    @(posedge clk);
    #1 b[i].valid = 1'b0;
    @(negedge clk);
    data = rd_w[i];
    err  = err_w[i];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    tests = 0; fails = 0; armed = 1'b0; rst = 1'b1;
    for (int i = 0; i < 2; i++) b[i] = '{valid: 1'b0, we: 1'b0, addr: 32'd0, wdata: 32'd0, rsp_ready: 1'b1};

    do_reset();
    @(negedge clk);
    check("reset rsp_valid", 64'(rv_w[0]), 64'd0);
    check("reset req_ready", 64'(rdy_w[0]), 64'd1);
    check("reset rsp_rdata", 64'(rd_w[0]), 64'd0);
    check("reset rsp_err", 64'(err_w[0]), 64'd0);
    check("reset xTIP", 64'(tip_w[0]), 64'd0);
    check("reset xSIP", 64'(sip_w[0]), 64'd0);

    // Read of mtime accepted on the 11th edge after release sees 10.
    repeat (9) @(posedge clk);
    rd(0, A_TM_LO, d, e);
    check("mtime_lo at cycle 10", 64'(d), 64'd10);
    check("mtime_lo err", 64'(e), 64'd0);
    check("xTIP early", 64'(tip_w[0]), 64'd0);

    // mtimecmp = 20: mtime hits 20 on edge 20, xTIP rises on edge 21.
    wr(0, A_CMP_LO, 32'd20);
    wr(0, A_CMP_HI, 32'd0);
    repeat (6) @(negedge clk);
    check("xTIP before compare", 64'(tip_w[0]), 64'd0);
    @(negedge clk);
    check("xTIP rises", 64'(tip_w[0]), 64'd1);
    repeat (3) @(negedge clk);
    check("xTIP level holds", 64'(tip_w[0]), 64'd1);
    wr(0, A_CMP_HI, 32'd1);
    @(negedge clk);
    check("xTIP 1 cycle after cmp raise", 64'(tip_w[0]), 64'd1);
    @(negedge clk);
    check("xTIP 2 cycles after cmp raise", 64'(tip_w[0]), 64'd0);

    // msip: only bit 0 sticks.
    wr(0, A_MSIP, 32'hFFFF_FFFF);
    @(negedge clk);
    check("xSIP 1 cycle after write", 64'(sip_w[0]), 64'd0);
    @(negedge clk);
    check("xSIP 2 cycles after write", 64'(sip_w[0]), 64'd1);
    rd(0, A_MSIP, d, e);
    check("msip readback", 64'(d), 64'd1);
    wr(0, A_MSIP, 32'd0);
    repeat (2) @(negedge clk);
    check("xSIP cleared", 64'(sip_w[0]), 64'd0);

    // Back-to-back reads, one response per cycle.
    @(posedge clk);
    #1 b[0].valid = 1'b1; b[0].addr = A_MSIP;
    @(posedge clk);
    #1 b[0].addr = A_CMP_HI;
    @(negedge clk);
    check("b2b #1 valid", 64'(rv_w[0]), 64'd1);
    check("b2b #1 msip", 64'(rd_w[0]), 64'd0);
    @(posedge clk);
    #1 b[0].addr = A_CMP_LO;
    @(negedge clk);
    check("b2b #2 cmp_hi", 64'(rd_w[0]), 64'd1);
    @(posedge clk);
    #1 b[0].valid = 1'b0;
    @(negedge clk);
    check("b2b #3 cmp_lo", 64'(rd_w[0]), 64'd20);

    // Backpressure: response held for 5 cycles, pending request not taken.
    @(posedge clk);
    #1 b[0].valid = 1'b1; b[0].addr = A_CMP_LO;
    @(posedge clk);
    #1 b[0].rsp_ready = 1'b0; b[0].addr = A_MSIP;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold rsp_valid", 64'(rv_w[0]), 64'd1);
      check("hold rsp_rdata", 64'(rd_w[0]), 64'd20);
      check("hold req_ready", 64'(rdy_w[0]), 64'd0);
    end
    #1 b[0].rsp_ready = 1'b1;
    @(posedge clk);
    #1 b[0].valid = 1'b0;
    @(negedge clk);
    check("after hold msip read", 64'(rd_w[0]), 64'd0);

    // Error accesses: unmapped, misaligned, wrong base.
    rd(0, 32'h0200_1000, d, e);
    check("unmapped err", 64'(e), 64'd1);
    check("unmapped rdata", 64'(d), 64'd0);
    rd(0, 32'h0200_BFF9, d, e);
    check("misaligned err", 64'(e), 64'd1);
    rd(0, 32'h0300_BFF8, d, e);
    check("base mismatch err", 64'(e), 64'd1);
    check("base mismatch rdata", 64'(d), 64'd0);

    // Reset while a response is pending.
    @(posedge clk);
    #1 b[0].valid = 1'b1; b[0].addr = A_CMP_LO;
    @(posedge clk);
    #1 b[0].valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("pre-reset rsp_valid", 64'(rv_w[0]), 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset drops rsp_valid", 64'(rv_w[0]), 64'd0);
    check("reset clears xTIP", 64'(tip_w[0]), 64'd0);

    // TICK_DIV=4: lo write lands on the tick edge and must load exactly.
    wr(1, A_TM_HI, 32'hFFFF_FFFF);
    wr(1, A_TM_LO, 32'hFFFF_FFFE);
    rd(1, A_TM_HI, d, e);
    check("div4 hi before wrap", 64'(d), 64'hFFFF_FFFF);
    rd(1, A_TM_LO, d, e);
    check("div4 lo write on tick", 64'(d), 64'hFFFF_FFFE);
    repeat (4) @(posedge clk);
    rd(1, A_TM_HI, d, e);
    check("div4 hi after wrap", 64'(d), 64'd0);
    rd(1, A_TM_LO, d, e);
    check("div4 lo after wrap", 64'(d), 64'd0);
    rd(1, A_TM_LO, d, e);
    check("div4 lo +1", 64'(d), 64'd1);
    repeat (2) @(posedge clk);
    rd(1, A_TM_LO, d, e);
    check("div4 lo +1 after 4 cycles", 64'(d), 64'd2);

    // mtimecmp returned to all-ones by the mid-transaction reset.
    rd(0, A_CMP_LO, d, e);
    check("cmp_lo after reset", 64'(d), 64'hFFFF_FFFF);
    rd(0, A_CMP_HI, d, e);
    check("cmp_hi after reset", 64'(d), 64'hFFFF_FFFF);
    check("xTIP after reset", 64'(tip_w[0]), 64'd0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
